// File: rtl/block_map_ctrl_pkg.sv
// Shared map geometry, FSM states and LFSR step for the block-map writer.
// The geometry constants are also used by the block-map read-address logic.
package block_map_ctrl_pkg;

  localparam int MAP_COLS  = 33;
  localparam int MAP_ROWS  = 27;
  localparam int MAP_CELLS = 891;
  localparam int MAP_DEPTH = 896;
  localparam int MAP_AW    = 10;

  typedef enum logic {
    S_INIT,
    S_RUN
  } state_e;

  // Fibonacci taps 16,14,13,11; shift left, feedback into bit 0
  function automatic logic [15:0] lfsr_next(input logic [15:0] l);
    logic fb;
    fb = l[15] ^ l[13] ^ l[12] ^ l[10];
    return {l[14:0], fb};
  endfunction

endpackage

// File: rtl/block_map_ctrl_rr_arbiter.sv
// Combinational round-robin arbiter: first set bit of req_vec above ptr,
// wrapping; grant_vec is one-hot or zero.
module rr_arbiter #(
  parameter int N  = 4,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req_vec,
  input  logic [IW-1:0] ptr,
  input  logic          en,
  output logic [N-1:0]  grant_vec,
  output logic [IW-1:0] idx
);

  always_comb begin
    int  j;
    logic found;
    grant_vec = '0;
    idx       = '0;
    found     = 1'b0;
    j         = 0;
    for (int k = 1; k <= N; k++) begin
      j = int'(ptr) + k;
      if (j >= N) j = j - N;
      if (en && !found && req_vec[j]) begin
        found        = 1'b1;
        grant_vec[j] = 1'b1;
        idx          = IW'(j);
      end
    end
  end

endmodule

// File: rtl/block_map_ctrl.sv
// Block-map RAM write-port owner: random level fill, then round-robin
// destroy-request service; all writes confined to display blanking.
module block_map_ctrl
  import block_map_ctrl_pkg::*;
#(
  parameter int          N_REQ     = 4,
  parameter int          DENSITY   = 9,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      display_on,
  input  logic                      start_init,
  input  logic [N_REQ-1:0]          req,
  input  logic [MAP_AW*N_REQ-1:0]   req_addr,
  output logic [N_REQ-1:0]          grant,
  output logic                      init_done,
  output logic [MAP_AW-1:0]         waddr,
  output logic                      we,
  output logic                      wdata
);

  localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  localparam logic [MAP_AW-1:0] CELLS_A = MAP_AW'(MAP_CELLS);
  localparam logic [MAP_AW-1:0] LAST_A  = MAP_AW'(MAP_DEPTH - 1);
  localparam logic [MAP_AW-1:0] SPAWN_A = MAP_AW'(MAP_COLS);
  localparam logic [5:0]        LAST_C  = 6'(MAP_COLS - 1);
  localparam logic [4:0]        DEN_5   = 5'(DENSITY);

  state_e            state_q, state_d;
  logic [MAP_AW-1:0] cnt_q, cnt_d;
  logic [5:0]        col_q, col_d;
  logic [4:0]        row_q, row_d;
  logic [15:0]       lfsr_q, lfsr_d;
  logic [IW-1:0]     rr_ptr_q, rr_ptr_d;
  logic [N_REQ-1:0]  grant_q, grant_d;
  logic              init_done_q, init_done_d;
  logic [MAP_AW-1:0] waddr_q, waddr_d;
  logic              we_q, we_d;
  logic              wdata_q, wdata_d;

  logic              arb_en;
  logic [N_REQ-1:0]  arb_grant;
  logic [IW-1:0]     arb_idx;
  logic [MAP_AW-1:0] sel_addr;
  logic              fill_bit;

  assign arb_en = (state_q == S_RUN) && init_done_q
                  && !display_on && !start_init;

  rr_arbiter #(
    .N  (N_REQ),
    .IW (IW)
  ) u_arb (
    .req_vec   (req & ~grant_q),
    .ptr       (rr_ptr_q),
    .en        (arb_en),
    .grant_vec (arb_grant),
    .idx       (arb_idx)
  );

  always_comb begin
    sel_addr = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (arb_grant[i]) sel_addr = req_addr[i*MAP_AW +: MAP_AW];
    end
  end

  always_comb begin
    logic in_map, dense, pillar, spawn;
    in_map   = cnt_q < CELLS_A;
    dense    = {1'b0, lfsr_q[3:0]} < DEN_5;
    pillar   = col_q[0] & row_q[0];
    spawn    = (cnt_q == '0) || (cnt_q == MAP_AW'(1)) || (cnt_q == SPAWN_A);
    fill_bit = in_map && dense && !pillar && !spawn;
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    col_d       = col_q;
    row_d       = row_q;
    lfsr_d      = lfsr_q;
    rr_ptr_d    = rr_ptr_q;
    grant_d     = '0;
    init_done_d = init_done_q;
    waddr_d     = waddr_q;
    we_d        = 1'b0;
    wdata_d     = wdata_q;
    if (start_init) begin
      // LFSR deliberately not reseeded so each level differs
      state_d     = S_INIT;
      cnt_d       = '0;
      col_d       = '0;
      row_d       = '0;
      init_done_d = 1'b0;
    end else begin
      unique case (state_q)
        S_INIT: begin
          if (!display_on) begin
            we_d    = 1'b1;
            waddr_d = cnt_q;
            wdata_d = fill_bit;
            cnt_d   = cnt_q + MAP_AW'(1);
            lfsr_d  = lfsr_next(lfsr_q);
            if (col_q == LAST_C) begin
              col_d = '0;
              row_d = row_q + 5'd1;
            end else begin
              col_d = col_q + 6'd1;
            end
            if (cnt_q == LAST_A) state_d = S_RUN;
          end
        end
        S_RUN: begin
          init_done_d = 1'b1;
          if (|arb_grant) begin
            grant_d  = arb_grant;
            rr_ptr_d = arb_idx;
            waddr_d  = sel_addr;
            wdata_d  = 1'b0;
            we_d     = sel_addr < CELLS_A;
          end
        end
        default: state_d = S_INIT;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_INIT;
      cnt_q       <= '0;
      col_q       <= '0;
      row_q       <= '0;
      lfsr_q      <= LFSR_SEED;
      rr_ptr_q    <= IW'(N_REQ - 1);
      grant_q     <= '0;
      init_done_q <= 1'b0;
      waddr_q     <= '0;
      we_q        <= 1'b0;
      wdata_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      col_q       <= col_d;
      row_q       <= row_d;
      lfsr_q      <= lfsr_d;
      rr_ptr_q    <= rr_ptr_d;
      grant_q     <= grant_d;
      init_done_q <= init_done_d;
      waddr_q     <= waddr_d;
      we_q        <= we_d;
      wdata_q     <= wdata_d;
    end
  end

  assign grant     = grant_q;
  assign init_done = init_done_q;
  assign waddr     = waddr_q;
  assign we        = we_q;
  assign wdata     = wdata_q;

endmodule
